demux_dispatcher: RTL and testbench

- Sequencing controller for the 8-bit 1-to-8 demultiplexer.
- Accepts one byte at a time from an upstream producer with a valid/ready handshake. Drives the demux data and select inputs, raises a one-hot per-channel valid, and waits for that channel's ack.
- Supports addressed delivery to one channel, or broadcast delivery to all 8 channels in turn (0 to 7).

---
 rtl/demux_dispatcher.sv | 137 +++++++++++++
 tb/tb_demux_dispatcher.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/demux_dispatcher.sv
// demux_dispatcher: feeds single bytes from a valid/ready producer into an 8-way demux, addressed or broadcast 0..7.
// Latency: one cycle from accept to ch_valid; one cycle per broadcast channel when acks are already high.
// Backpressure: in_ready is low for the whole delivery; optional per-channel timeout under DEMUX_DISPATCH_TIMEOUT_EN.
module demux_dispatcher #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [2:0] in_dest,
  input  logic       in_bcast,
  output logic [7:0] dm_data,
  output logic [2:0] dm_sel,
  output logic [7:0] ch_valid,
  input  logic [7:0] ch_ack,
  output logic       busy,
  output logic       err,
  output logic [7:0] drop_count
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t     state, state_nx;
  logic [7:0] hold, hold_nx;
  logic [2:0] cur, cur_nx;
  logic       bcast, bcast_nx;
  logic [7:0] dm_data_nx;
  logic [2:0] dm_sel_nx;
  logic [7:0] ch_valid_nx;
  logic [2:0] first_sel;
  logic       ack_cur;
  logic       timeout;
  logic       done;

  assign in_ready  = (state == IDLE);
  assign first_sel = in_bcast ? 3'd0 : in_dest;
  assign ack_cur   = ch_ack[cur];
  assign done      = (state == SEND) && (ack_cur || timeout);

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
  logic [7:0] tcnt;

  // A timeout is only taken when no ack is present on that edge, so an ack always wins.
  assign timeout = (state == SEND) && !ack_cur && (tcnt == 8'(TIMEOUT_CYCLES - 1));

  // Per-channel wait counter, error pulse and saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt       <= 8'd0;
      err        <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      err <= timeout;
      if (timeout && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;
      if (state == IDLE || done)
        tcnt <= 8'd0;
      else
        tcnt <= tcnt + 8'd1;
    end
  end
`else
  assign timeout    = 1'b0;
  assign err        = 1'b0;
  assign drop_count = 8'd0;
`endif

  // State register and registered demux-facing outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hold     <= 8'd0;
      cur      <= 3'd0;
      bcast    <= 1'b0;
      dm_data  <= 8'd0;
      dm_sel   <= 3'd0;
      ch_valid <= 8'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      hold     <= hold_nx;
      cur      <= cur_nx;
      bcast    <= bcast_nx;
      dm_data  <= dm_data_nx;
      dm_sel   <= dm_sel_nx;
      ch_valid <= ch_valid_nx;
      busy     <= (state_nx == SEND);
    end
  end

  // Next-state logic: accept in IDLE, then step through channels until the last ack or timeout.
  always_comb begin
    state_nx    = state;
    hold_nx     = hold;
    cur_nx      = cur;
    bcast_nx    = bcast;
    dm_data_nx  = dm_data;
    dm_sel_nx   = dm_sel;
    ch_valid_nx = ch_valid;
    case (state)
      IDLE: begin
        dm_data_nx  = 8'd0;
        dm_sel_nx   = 3'd0;
        ch_valid_nx = 8'd0;
        if (in_valid) begin
          hold_nx     = in_data;
          cur_nx      = first_sel;
          bcast_nx    = in_bcast;
          dm_data_nx  = in_data;
          dm_sel_nx   = first_sel;
          ch_valid_nx = 8'b1 << first_sel;
          state_nx    = SEND;
        end
      end
      SEND: begin
        dm_data_nx = hold;
        if (done) begin
          if (bcast && cur != 3'd7) begin
            // Next broadcast channel follows with no idle gap; cur never wraps.
            cur_nx      = cur + 3'd1;
            dm_sel_nx   = cur + 3'd1;
            ch_valid_nx = 8'b1 << (cur + 3'd1);
          end else begin
            state_nx    = IDLE;
            dm_data_nx  = 8'd0;
            dm_sel_nx   = 3'd0;
            ch_valid_nx = 8'd0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_demux_dispatcher.sv
// tb_demux_dispatcher: directed vectors against hand-computed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
// Timeout vectors run only when DEMUX_DISPATCH_TIMEOUT_EN is defined.
module tb_demux_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       in_bcast;
  logic [7:0] dm_data;
  logic [2:0] dm_sel;
  logic [7:0] ch_valid;
  logic [7:0] ch_ack;
  logic       busy;
  logic       err;
  logic [7:0] drop_count;

  int n_pass = 0;
  int n_total = 0;
  int busy_cycles;

  demux_dispatcher #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_bcast(in_bcast),
    .dm_data(dm_data), .dm_sel(dm_sel), .ch_valid(ch_valid), .ch_ack(ch_ack),
    .busy(busy), .err(err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [7:0] d, input logic [2:0] dst, input logic bc);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
    in_bcast = bc;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_dest = 3'd0; in_bcast = 1'b0; ch_ack = 8'h00;
    tick(); tick();
    check("rst_ch_valid", ch_valid, 8'h00);
    check("rst_dm_data", dm_data, 8'h00);
    check("rst_dm_sel", dm_sel, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_drop", drop_count, 8'd0);
    reset = 1'b0;
    tick();
    check("idle_ready", in_ready, 1'b1);

    // Addressed delivery, ack two cycles after ch_valid rises.
    offer(8'hA5, 3'd3, 1'b0);
    tick();
    in_valid = 1'b0;
    check("addr_ch_valid", ch_valid, 8'h08);
    check("addr_dm_sel", dm_sel, 3'd3);
    check("addr_dm_data", dm_data, 8'hA5);
    check("addr_busy", busy, 1'b1);
    check("addr_ready", in_ready, 1'b0);
    tick();
    check("addr_hold", ch_valid, 8'h08);
    ch_ack = 8'h08;
    tick();
    ch_ack = 8'h00;
    check("addr_done_valid", ch_valid, 8'h00);
    check("addr_done_data", dm_data, 8'h00);
    check("addr_done_busy", busy, 1'b0);
    check("addr_done_ready", in_ready, 1'b1);

    // Broadcast with every ack already high: one channel per cycle, in_dest ignored.
    offer(8'h3C, 3'd5, 1'b1);
    ch_ack = 8'hFF;
    tick();
    in_valid = 1'b0;
    busy_cycles = 0;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("bc_valid%0d", k), ch_valid, 8'h01 << k);
      check($sformatf("bc_data%0d", k), dm_data, 8'h3C);
      if (busy) busy_cycles++;
      tick();
    end
    check("bc_end_valid", ch_valid, 8'h00);
    check("bc_end_busy", busy, 1'b0);
    check("bc_busy_cycles", busy_cycles, 8);
    ch_ack = 8'h00;

    // Ack on a non-selected channel is ignored.
    offer(8'h5A, 3'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    ch_ack = 8'h10;
    tick();
    check("wrong_ack_valid", ch_valid, 8'h04);
    check("wrong_ack_busy", busy, 1'b1);
    ch_ack = 8'h04;
    tick();
    ch_ack = 8'h00;
    check("right_ack_valid", ch_valid, 8'h00);

    // Back-pressure: second byte waits while the first is undelivered.
    offer(8'h11, 3'd1, 1'b0);
    tick();
    in_data = 8'h22; in_dest = 3'd6;
    check("bp_ready_low", in_ready, 1'b0);
    tick(); tick(); tick();
    check("bp_data_held", dm_data, 8'h11);
    check("bp_valid_held", ch_valid, 8'h02);
    ch_ack = 8'h02;
    tick();
    ch_ack = 8'h00;
    check("bp_idle_ready", in_ready, 1'b1);
    check("bp_idle_valid", ch_valid, 8'h00);
    tick();
    in_valid = 1'b0;
    check("bp_second_data", dm_data, 8'h22);
    check("bp_second_valid", ch_valid, 8'h40);
    ch_ack = 8'h40;
    tick();
    ch_ack = 8'h00;
    tick(); tick();
    check("bp_no_dup_valid", ch_valid, 8'h00);
    check("bp_no_dup_busy", busy, 1'b0);

`ifndef DEMUX_DISPATCH_TIMEOUT_EN
    // Without the timeout a delivery waits indefinitely and never counts drops.
    offer(8'h99, 3'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    check("wait_valid", ch_valid, 8'h40);
    check("wait_err", err, 1'b0);
    check("wait_drop", drop_count, 8'd0);
    ch_ack = 8'h40;
    tick();
    ch_ack = 8'h00;
    check("wait_done", ch_valid, 8'h00);
`endif

    // Reset in the middle of a broadcast at channel 4.
    offer(8'h77, 3'd0, 1'b1);
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ch_ack = 8'h01 << k;
      tick();
    end
    ch_ack = 8'h00;
    check("mid_bc_valid", ch_valid, 8'h10);
    check("mid_bc_sel", dm_sel, 3'd4);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid", ch_valid, 8'h00);
    check("async_rst_data", dm_data, 8'h00);
    check("async_rst_busy", busy, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("post_rst_ready", in_ready, 1'b1);
    ch_ack = 8'hFF;
    tick(); tick();
    check("post_rst_no_resume", ch_valid, 8'h00);
    ch_ack = 8'h00;

`ifdef DEMUX_DISPATCH_TIMEOUT_EN
    // Four SEND cycles without ack drop the delivery.
    offer(8'hE1, 3'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("to_pre_err", err, 1'b0);
    check("to_pre_valid", ch_valid, 8'h40);
    tick();
    check("to_err", err, 1'b1);
    check("to_drop1", drop_count, 8'd1);
    check("to_idle", in_ready, 1'b1);
    check("to_valid_clr", ch_valid, 8'h00);
    tick();
    check("to_err_pulse", err, 1'b0);

    // Ack on the timeout edge wins.
    offer(8'hE2, 3'd6, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    ch_ack = 8'h40;
    tick();
    ch_ack = 8'h00;
    check("ack_wins_err", err, 1'b0);
    check("ack_wins_drop", drop_count, 8'd1);
    check("ack_wins_idle", ch_valid, 8'h00);

    // 299 further drops: 300 total saturates at 255.
    for (int i = 0; i < 299; i++) begin
      offer(8'hE3, 3'd6, 1'b0);
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
    end
    check("drop_sat", drop_count, 8'd255);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
